// File: rtl/energy_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// energy_pkg
// Shared definitions for the energy accumulator slice:
//   - state_t      : two-state control enumeration (ACCUM, HOLD)
//   - DEF_*        : default DATA_W / LEN_LOG2 / ACC_W values
//   - all_ones(w)  : constant function giving a vector with the low w bits set,
//                    used to build saturation ceilings of any width up to MAX_W
// -----------------------------------------------------------------------------
package energy_pkg;

  localparam int DEF_DATA_W   = 80;
  localparam int DEF_LEN_LOG2 = 10;
  localparam int DEF_ACC_W    = 88;

  // Widest vector all_ones() can describe; callers cast the result down.
  localparam int MAX_W = 256;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/energy_accumulator_if.sv
// -----------------------------------------------------------------------------
// energy_accumulator_if
// Groups the sample input stream, the result output stream and the abort line.
//
// Handshake rules (both streams): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds data stable while
// valid is high and ready is low; ready may depend on state but never on valid.
//
// Signals:
//   sq_data/sq_valid/sq_ready : incoming square words (producer = master)
//   sum/mean/sat/out_valid/out_ready : block result (consumer = master)
//   err : sticky negative-input flag
//   clr : synchronous abort of the current block and any pending result
// Modports: master (traffic source/sink), slave (the accumulator).
// -----------------------------------------------------------------------------
interface energy_accumulator_if
  import energy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic [DATA_W-1:0] sq_data;
  logic              sq_valid;
  logic              sq_ready;
  logic              clr;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] mean;
  logic              sat;
  logic              err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output sq_data, sq_valid, clr, out_ready,
    input  sq_ready, sum, mean, sat, err, out_valid
  );

  modport slave (
    input  sq_data, sq_valid, clr, out_ready,
    output sq_ready, sum, mean, sat, err, out_valid
  );

endinterface

// File: rtl/energy_accumulator_sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Combinational unsigned saturating adder: ACC_W-bit accumulator plus a
// zero-extended DATA_W-bit addend. On carry out of ACC_W bits the result
// clamps to all-ones and o_ovf is raised.
//   i_a   : accumulator value (ACC_W)
//   i_b   : addend, unsigned (DATA_W, DATA_W <= ACC_W)
//   o_sum : saturated sum (ACC_W)
//   o_ovf : saturation occurred
// -----------------------------------------------------------------------------
module sat_add
  import energy_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam logic [ACC_W-1:0] SAT_ONES = ACC_W'(all_ones(ACC_W));

  // One extra bit captures the carry that signals overflow.
  logic [ACC_W:0] w_wide;

  assign w_wide = {1'b0, i_a} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_b};
  assign o_ovf  = w_wide[ACC_W];
  assign o_sum  = o_ovf ? SAT_ONES : w_wide[ACC_W-1:0];

endmodule

// File: rtl/energy_accumulator.sv
// -----------------------------------------------------------------------------
// energy_accumulator
// Sums blocks of N = 2**LEN_LOG2 non-negative square words with saturation and
// presents sum, mean (sum >> LEN_LOG2, clamped to DATA_W) and a per-block
// saturation flag on a valid/ready result port. Words with MSB set are counted
// but add zero, and raise a sticky err flag.
// Ports:
//   clock     : rising-edge clock
//   aclr_n    : asynchronous active-low reset
//   bus       : energy_accumulator_if.slave (sample stream, result, clr, err)
//   dbg_state : current control state for observation
// Control: ACCUM accepts samples; the last sample of a block moves to HOLD,
// which presents the result until out_ready. clr returns to an empty ACCUM.
// -----------------------------------------------------------------------------
module energy_accumulator
  import energy_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_LOG2 = DEF_LEN_LOG2,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  energy_accumulator_if.slave   bus,
  output state_t                dbg_state
);

  localparam logic [LEN_LOG2-1:0] CNT_ONE = LEN_LOG2'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ACC_W-1:0]    r_acc;
  logic [LEN_LOG2-1:0] r_cnt;
  logic                r_blk_sat;
  logic [ACC_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_mean;
  logic                r_sat;
  logic                r_err;

  logic                w_sq_ready;
  logic                w_out_valid;
  logic                w_neg;
  logic [DATA_W-1:0]   w_addend;
  logic [ACC_W-1:0]    w_add_sum;
  logic                w_add_ovf;
  logic                w_xfer;
  logic                w_last;
  logic                w_blk_sat_next;
  logic [ACC_W-1:0]    w_shift;
  logic [DATA_W-1:0]   w_mean;

  // A negative word contributes nothing; otherwise its MSB is zero anyway,
  // so only bits DATA_W-2:0 reach the adder.
  assign w_neg    = bus.sq_data[DATA_W-1];
  assign w_addend = w_neg ? '0 : {1'b0, bus.sq_data[DATA_W-2:0]};

  // clr wins over a transfer presented in the same cycle.
  assign w_xfer         = (r_state == ACCUM) && bus.sq_valid && !bus.clr;
  assign w_last         = &r_cnt;
  assign w_blk_sat_next = r_blk_sat | w_add_ovf;

  sat_add #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  // Mean is taken from the post-add value so it is ready with the last sample.
  assign w_shift = w_add_sum >> LEN_LOG2;

  generate
    if (ACC_W > DATA_W) begin : g_mean_clamp
      localparam logic [DATA_W-1:0] MEAN_ONES = DATA_W'(all_ones(DATA_W));
      assign w_mean = (|w_shift[ACC_W-1:DATA_W]) ? MEAN_ONES : w_shift[DATA_W-1:0];
    end else begin : g_mean_fit
      assign w_mean = w_shift[DATA_W-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) r_state <= ACCUM;
    else         r_state <= w_next_state;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_sq_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_sq_ready = 1'b1;
        if (w_xfer && w_last) w_next_state = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next_state = ACCUM;
      end
      default: w_next_state = ACCUM;
    endcase
    if (bus.clr) w_next_state = ACCUM;
  end

  // Datapath: accumulator, sample counter, result and flag registers.
  // The counter wraps to zero naturally on the last transfer of a block; in
  // HOLD no transfers occur, so it cannot advance until the next block.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_blk_sat <= 1'b0;
      r_sum     <= '0;
      r_mean    <= '0;
      r_sat     <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.clr) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_blk_sat <= 1'b0;
      r_sum     <= '0;
      r_mean    <= '0;
      r_sat     <= 1'b0;
      r_err     <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_xfer) begin
        r_acc     <= w_add_sum;
        r_cnt     <= r_cnt + CNT_ONE;
        r_blk_sat <= w_blk_sat_next;
        if (w_neg) r_err <= 1'b1;
        if (w_last) begin
          r_sum  <= w_add_sum;
          r_mean <= w_mean;
          r_sat  <= w_blk_sat_next;
        end
      end
    end else if (bus.out_ready) begin
      // Result consumed: start the next block empty; sum/mean keep their
      // last values but are no longer flagged valid.
      r_acc     <= '0;
      r_cnt     <= '0;
      r_blk_sat <= 1'b0;
      r_sat     <= 1'b0;
    end
  end

  assign bus.sq_ready  = w_sq_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.mean      = r_mean;
  assign bus.sat       = r_sat;
  assign bus.err       = r_err;
  assign dbg_state     = r_state;

endmodule
